// File: rtl/cpu_mem_axi_posted_bridge_if.sv
// cpu_mem_axi_posted_bridge_if: CPU memory port plus AXI4 master channels of the posted-write bridge.
// master = bridge side, slave = CPU/interconnect side.
interface cpu_mem_axi_posted_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   Address;
  logic                    MemWrite;
  logic [DATA_WIDTH-1:0]   Write_data;
  logic [DATA_WIDTH/8-1:0] Write_strb;
  logic                    MemRead;
  logic                    Mem_Req_Ready;
  logic [DATA_WIDTH-1:0]   Read_data;
  logic                    Read_data_Valid;
  logic                    Read_data_Ready;
  logic                    wbuf_empty;
  logic [ADDR_WIDTH-1:0]   cpu_mem_araddr;
  logic                    cpu_mem_arvalid;
  logic                    cpu_mem_arready;
  logic [2:0]              cpu_mem_arsize;
  logic [1:0]              cpu_mem_arburst;
  logic [7:0]              cpu_mem_arlen;
  logic [DATA_WIDTH-1:0]   cpu_mem_rdata;
  logic                    cpu_mem_rvalid;
  logic                    cpu_mem_rlast;
  logic                    cpu_mem_rready;
  logic [ADDR_WIDTH-1:0]   cpu_mem_awaddr;
  logic                    cpu_mem_awvalid;
  logic                    cpu_mem_awready;
  logic [2:0]              cpu_mem_awsize;
  logic [1:0]              cpu_mem_awburst;
  logic [7:0]              cpu_mem_awlen;
  logic [DATA_WIDTH-1:0]   cpu_mem_wdata;
  logic [DATA_WIDTH/8-1:0] cpu_mem_wstrb;
  logic                    cpu_mem_wvalid;
  logic                    cpu_mem_wlast;
  logic                    cpu_mem_wready;
  logic                    cpu_mem_bvalid;
  logic                    cpu_mem_bready;
  modport master (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
           cpu_mem_arready, cpu_mem_rdata, cpu_mem_rvalid, cpu_mem_rlast,
           cpu_mem_awready, cpu_mem_wready, cpu_mem_bvalid,
    output Mem_Req_Ready, Read_data, Read_data_Valid, wbuf_empty,
           cpu_mem_araddr, cpu_mem_arvalid, cpu_mem_arsize, cpu_mem_arburst, cpu_mem_arlen,
           cpu_mem_rready, cpu_mem_awaddr, cpu_mem_awvalid, cpu_mem_awsize, cpu_mem_awburst,
           cpu_mem_awlen, cpu_mem_wdata, cpu_mem_wstrb, cpu_mem_wvalid, cpu_mem_wlast, cpu_mem_bready
  );
  modport slave (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
           cpu_mem_arready, cpu_mem_rdata, cpu_mem_rvalid, cpu_mem_rlast,
           cpu_mem_awready, cpu_mem_wready, cpu_mem_bvalid,
    input  Mem_Req_Ready, Read_data, Read_data_Valid, wbuf_empty,
           cpu_mem_araddr, cpu_mem_arvalid, cpu_mem_arsize, cpu_mem_arburst, cpu_mem_arlen,
           cpu_mem_rready, cpu_mem_awaddr, cpu_mem_awvalid, cpu_mem_awsize, cpu_mem_awburst,
           cpu_mem_awlen, cpu_mem_wdata, cpu_mem_wstrb, cpu_mem_wvalid, cpu_mem_wlast, cpu_mem_bready
  );
endinterface

// File: rtl/cpu_mem_axi_posted_bridge.sv
// cpu_mem_axi_posted_bridge: CPU data port to AXI4 master with posted write buffer and RAW-ordered single-beat reads.
// Define MEM_RAW_ADDR_CHECK_EN to let reads bypass pending writes to other word addresses.
module cpu_mem_axi_posted_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int MAX_OUT_B  = 4
) (
  input logic                         cpu_clk,
  input logic                         cpu_resetn,
  cpu_mem_axi_posted_bridge_if.master bus
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int PW  = $clog2(WBUF_DEPTH);
  localparam int LSB = $clog2(SW);
  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_AR, R_DATA} rstate_e;
  rstate_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [WBUF_DEPTH];
  logic [SW-1:0]         strb_q [WBUF_DEPTH];
  logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         head;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [3:0]            bcnt_q, bcnt_d;
  logic                  empty, full, push, pop, aw_hs, w_hs, aw_fin, w_fin, b_dec, buf_idle, hazard;
  assign head     = rd_ptr_q[PW-1:0];
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == head);
  assign push     = bus.MemWrite && !full && state_q == R_IDLE;
  assign aw_hs    = awvalid_q && bus.cpu_mem_awready;
  assign w_hs     = wvalid_q && bus.cpu_mem_wready;
  assign aw_fin   = aw_done_q || aw_hs;
  assign w_fin    = w_done_q || w_hs;
  assign pop      = !empty && aw_fin && w_fin;
  assign b_dec    = bus.cpu_mem_bvalid && bcnt_q != 4'd0;
  assign buf_idle = empty && bcnt_q == 4'd0;
  assign wr_ptr_d  = wr_ptr_q + (PW+1)'(push);
  assign rd_ptr_d  = rd_ptr_q + (PW+1)'(pop);
  assign bcnt_d    = bcnt_q + 4'(aw_hs) - 4'(b_dec);
  assign aw_done_d = !pop && aw_fin;
  assign w_done_d  = !pop && w_fin;
  // Valids look at the post-edge head so a new entry is offered right after the previous pops
  assign awvalid_d = (wr_ptr_d != rd_ptr_d) && !aw_done_d && (bcnt_d < 4'(MAX_OUT_B));
  assign wvalid_d  = (wr_ptr_d != rd_ptr_d) && !w_done_d;
  assign arvalid_d = state_d == R_AR;
`ifdef MEM_RAW_ADDR_CHECK_EN
  logic [ADDR_WIDTH-1:LSB] hist_q [MAX_OUT_B];
  logic [PW:0]             occ;
  logic [PW-1:0]           off;
  assign occ = wr_ptr_q - rd_ptr_q;
  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < occ && addr_q[i][ADDR_WIDTH-1:LSB] == bus.Address[ADDR_WIDTH-1:LSB]) hazard = 1'b1;
    end
    // B returns in order, so the newest bcnt_q history slots are the ones still pending
    for (int i = 0; i < MAX_OUT_B; i++)
      if (4'(i) < bcnt_q && hist_q[i] == bus.Address[ADDR_WIDTH-1:LSB]) hazard = 1'b1;
  end
  always_ff @(posedge cpu_clk)
    if (aw_hs) begin
      hist_q[0] <= bus.cpu_mem_awaddr[ADDR_WIDTH-1:LSB];
      for (int i = 1; i < MAX_OUT_B; i++) hist_q[i] <= hist_q[i-1];
    end
`else
  assign hazard = !buf_idle;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE:  if (bus.MemRead && !push) state_d = hazard ? R_DRAIN : R_AR;
      R_DRAIN: if (!hazard) state_d = R_AR;
      R_AR:    if (arvalid_q && bus.cpu_mem_arready) state_d = R_DATA;
      R_DATA:  if (bus.cpu_mem_rvalid && bus.cpu_mem_rready && bus.cpu_mem_rlast) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge cpu_clk)
    if (push) begin
      addr_q[wr_ptr_q[PW-1:0]] <= bus.Address;
      data_q[wr_ptr_q[PW-1:0]] <= bus.Write_data;
      strb_q[wr_ptr_q[PW-1:0]] <= bus.Write_strb;
    end
  always_ff @(posedge cpu_clk or negedge cpu_resetn)
    if (!cpu_resetn) begin
      state_q   <= R_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      bcnt_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      bcnt_q    <= bcnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  assign bus.Mem_Req_Ready   = push || (state_q == R_AR && arvalid_q && bus.cpu_mem_arready);
  assign bus.Read_data       = bus.cpu_mem_rdata;
  assign bus.Read_data_Valid = state_q == R_DATA && bus.cpu_mem_rvalid;
  assign bus.cpu_mem_rready  = state_q == R_DATA && bus.Read_data_Ready;
  assign bus.wbuf_empty      = buf_idle;
  assign bus.cpu_mem_araddr  = bus.Address;
  assign bus.cpu_mem_arvalid = arvalid_q;
  assign bus.cpu_mem_arsize  = 3'(LSB);
  assign bus.cpu_mem_arburst = 2'b01;
  assign bus.cpu_mem_arlen   = 8'd0;
  assign bus.cpu_mem_awaddr  = addr_q[head];
  assign bus.cpu_mem_awvalid = awvalid_q;
  assign bus.cpu_mem_awsize  = 3'(LSB);
  assign bus.cpu_mem_awburst = 2'b01;
  assign bus.cpu_mem_awlen   = 8'd0;
  assign bus.cpu_mem_wdata   = data_q[head];
  assign bus.cpu_mem_wstrb   = strb_q[head];
  assign bus.cpu_mem_wvalid  = wvalid_q;
  assign bus.cpu_mem_wlast   = wvalid_q;
  assign bus.cpu_mem_bready  = 1'b1;
endmodule

// File: tb/tb_cpu_mem_axi_posted_bridge.sv
// tb_cpu_mem_axi_posted_bridge: directed checks of posting, split AW/W, B limit, RAW ordering and read backpressure.
module tb_cpu_mem_axi_posted_bridge;
`ifdef MEM_RAW_ADDR_CHECK_EN
  localparam bit RAW_CHK = 1'b1;
`else
  localparam bit RAW_CHK = 1'b0;
`endif
  logic clk, rst_n;
  int   checks, failures, sent, awc, delivered;
  cpu_mem_axi_posted_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  cpu_mem_axi_posted_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WBUF_DEPTH(4), .MAX_OUT_B(4)) dut (
    .cpu_clk(clk), .cpu_resetn(rst_n), .bus(bus.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string tag);
    bus.cpu_mem_awready = 1'b1;
    bus.cpu_mem_wready  = 1'b1;
    bus.cpu_mem_bvalid  = 1'b1;
    #1;
    for (int n = 0; n < 40 && !bus.wbuf_empty; n++) tick();
    check(tag, bus.wbuf_empty, 1);
    bus.cpu_mem_awready = 1'b0;
    bus.cpu_mem_wready  = 1'b0;
    bus.cpu_mem_bvalid  = 1'b0;
  endtask
  initial begin
    checks = 0; failures = 0; sent = 0; awc = 0; delivered = 0;
    rst_n = 1'b0;
    bus.Address = '0; bus.MemWrite = 0; bus.Write_data = '0; bus.Write_strb = '0; bus.MemRead = 0;
    bus.Read_data_Ready = 1; bus.cpu_mem_arready = 0; bus.cpu_mem_rdata = '0; bus.cpu_mem_rvalid = 0;
    bus.cpu_mem_rlast = 0; bus.cpu_mem_awready = 0; bus.cpu_mem_wready = 0; bus.cpu_mem_bvalid = 0;
    repeat (2) tick();
    // T1: reset values, then reset mid-AW
    check("rst_awvalid", bus.cpu_mem_awvalid, 0);
    check("rst_wvalid", bus.cpu_mem_wvalid, 0);
    check("rst_arvalid", bus.cpu_mem_arvalid, 0);
    check("rst_empty", bus.wbuf_empty, 1);
    check("rst_bready", bus.cpu_mem_bready, 1);
    rst_n = 1'b1;
    tick();
    bus.MemWrite = 1; bus.Address = 32'h40; bus.Write_data = 32'h11; bus.Write_strb = 4'hF;
    #1 check("t1_acc", bus.Mem_Req_Ready, 1);
    tick();
    bus.MemWrite = 0;
    #1 check("t1_awvalid", bus.cpu_mem_awvalid, 1);
    check("t1_wvalid", bus.cpu_mem_wvalid, 1);
    check("t1_awaddr", bus.cpu_mem_awaddr, 32'h40);
    rst_n = 1'b0;
    #1 check("t1_rst_aw", bus.cpu_mem_awvalid, 0);
    check("t1_rst_w", bus.cpu_mem_wvalid, 0);
    check("t1_rst_ar", bus.cpu_mem_arvalid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_empty", bus.wbuf_empty, 1);
    check("t1_aw_after", bus.cpu_mem_awvalid, 0);
    // T2: four posted writes fill the buffer, the fifth waits for the first pop
    for (int i = 0; i < 4; i++) begin
      bus.MemWrite = 1; bus.Address = 32'h1000 + 32'(i * 4); bus.Write_data = 32'(i); bus.Write_strb = 4'hF;
      #1 check("t2_post", bus.Mem_Req_Ready, 1);
      tick();
    end
    bus.Address = 32'h1010; bus.Write_data = 32'h4;
    #1 check("t2_full", bus.Mem_Req_Ready, 0);
    tick();
    check("t2_full_hold", bus.Mem_Req_Ready, 0);
    bus.cpu_mem_awready = 1; bus.cpu_mem_wready = 1;
    #1 check("t2_head_addr", bus.cpu_mem_awaddr, 32'h1000);
    check("t2_head_data", bus.cpu_mem_wdata, 32'h0);
    check("t2_pop_cycle", bus.Mem_Req_Ready, 0);
    tick();
    check("t2_fifth", bus.Mem_Req_Ready, 1);
    check("t2_next_addr", bus.cpu_mem_awaddr, 32'h1004);
    tick();
    bus.MemWrite = 0;
    drain("t2_drain");
    // T3: W handshake three cycles before AW, single pop
    tick();
    bus.MemWrite = 1; bus.Address = 32'h100; bus.Write_data = 32'hDEADBEEF; bus.Write_strb = 4'hF;
    tick();
    bus.MemWrite = 0; bus.cpu_mem_wready = 1;
    #1 check("t3_wdata", bus.cpu_mem_wdata, 32'hDEADBEEF);
    check("t3_wstrb", bus.cpu_mem_wstrb, 4'hF);
    check("t3_wlast", bus.cpu_mem_wlast, 1);
    tick();
    bus.cpu_mem_wready = 0;
    #1 check("t3_wdone", bus.cpu_mem_wvalid, 0);
    tick();
    tick();
    check("t3_aw_hold", bus.cpu_mem_awvalid, 1);
    bus.cpu_mem_awready = 1;
    #1 check("t3_awaddr", bus.cpu_mem_awaddr, 32'h100);
    check("t3_awsize", bus.cpu_mem_awsize, 3'd2);
    check("t3_awburst", bus.cpu_mem_awburst, 2'b01);
    check("t3_awlen", bus.cpu_mem_awlen, 8'd0);
    tick();
    bus.cpu_mem_awready = 0;
    #1 check("t3_popped", bus.cpu_mem_awvalid, 0);
    check("t3_b_pend", bus.wbuf_empty, 0);
    bus.cpu_mem_bvalid = 1;
    tick();
    bus.cpu_mem_bvalid = 0;
    check("t3_empty", bus.wbuf_empty, 1);
    // T4: with B withheld only MAX_OUT_B AWs go out
    bus.cpu_mem_awready = 1; bus.cpu_mem_wready = 1;
    for (int c = 0; c < 20; c++) begin
      bus.MemWrite = sent < 6; bus.Address = 32'h400 + 32'(sent * 4); bus.Write_data = 32'(sent);
      #1;
      if (bus.MemWrite && bus.Mem_Req_Ready) sent++;
      if (bus.cpu_mem_awvalid && bus.cpu_mem_awready) awc++;
      tick();
    end
    bus.MemWrite = 0;
    check("t4_sent", 64'(sent), 6);
    check("t4_aw_count", 64'(awc), 4);
    check("t4_blocked", bus.cpu_mem_awvalid, 0);
    bus.cpu_mem_bvalid = 1;
    tick();
    bus.cpu_mem_bvalid = 0;
    check("t4_resume", bus.cpu_mem_awvalid, 1);
    drain("t4_drain");
    // T5: read of a written address waits for B
    tick();
    bus.cpu_mem_awready = 1; bus.cpu_mem_wready = 1;
    bus.MemWrite = 1; bus.Address = 32'h200; bus.Write_data = 32'h5;
    #1 check("t5_wacc", bus.Mem_Req_Ready, 1);
    tick();
    bus.MemWrite = 0; bus.MemRead = 1;
    #1 check("t5_no_ar0", bus.cpu_mem_arvalid, 0);
    check("t5_no_rdy", bus.Mem_Req_Ready, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t5_wait", bus.cpu_mem_arvalid, 0);
      tick();
    end
    bus.cpu_mem_bvalid = 1;
    tick();
    bus.cpu_mem_bvalid = 0;
    check("t5_b_edge", bus.cpu_mem_arvalid, 0);
    tick();
    check("t5_ar", bus.cpu_mem_arvalid, 1);
    check("t5_araddr", bus.cpu_mem_araddr, 32'h200);
    check("t5_arsize", bus.cpu_mem_arsize, 3'd2);
    check("t5_arlen", bus.cpu_mem_arlen, 8'd0);
    bus.cpu_mem_arready = 1;
    #1 check("t5_ar_rdy", bus.Mem_Req_Ready, 1);
    tick();
    bus.cpu_mem_arready = 0; bus.MemRead = 0;
    bus.cpu_mem_rvalid = 1; bus.cpu_mem_rlast = 1; bus.cpu_mem_rdata = 32'hCAFEF00D;
    #1 check("t5_rdv", bus.Read_data_Valid, 1);
    check("t5_rdata", bus.Read_data, 32'hCAFEF00D);
    check("t5_rready", bus.cpu_mem_rready, 1);
    tick();
    bus.cpu_mem_rvalid = 0; bus.cpu_mem_rlast = 0;
    #1 check("t5_rready_off", bus.cpu_mem_rready, 0);
    // T5b: read of another address while a write is still buffered
    bus.cpu_mem_awready = 0; bus.cpu_mem_wready = 0;
    bus.MemWrite = 1; bus.Address = 32'h200;
    tick();
    bus.MemWrite = 0; bus.MemRead = 1; bus.Address = 32'h300;
    tick();
    check("t5_bypass", bus.cpu_mem_arvalid, RAW_CHK);
    bus.cpu_mem_awready = 1; bus.cpu_mem_wready = 1; bus.cpu_mem_bvalid = 1;
    #1;
    for (int n = 0; n < 40 && !bus.cpu_mem_arvalid; n++) tick();
    check("t5_ar2", bus.cpu_mem_arvalid, 1);
    bus.cpu_mem_arready = 1;
    #1 check("t5_ar2_rdy", bus.Mem_Req_Ready, 1);
    tick();
    bus.cpu_mem_arready = 0; bus.MemRead = 0;
    bus.cpu_mem_rvalid = 1; bus.cpu_mem_rlast = 1; bus.cpu_mem_rdata = 32'h3;
    tick();
    bus.cpu_mem_rvalid = 0; bus.cpu_mem_rlast = 0;
    drain("t5_drain");
    // T6: read data held under CPU backpressure
    tick();
    bus.Read_data_Ready = 0; bus.MemRead = 1; bus.Address = 32'h80;
    #1 check("t6_no_rdy", bus.Mem_Req_Ready, 0);
    tick();
    check("t6_latency", bus.cpu_mem_arvalid, 1);
    bus.cpu_mem_arready = 1;
    #1 check("t6_ar_rdy", bus.Mem_Req_Ready, 1);
    tick();
    bus.cpu_mem_arready = 0; bus.MemRead = 0;
    bus.cpu_mem_rvalid = 1; bus.cpu_mem_rlast = 1; bus.cpu_mem_rdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      #1 check("t6_bp_rready", bus.cpu_mem_rready, 0);
      check("t6_bp_rdv", bus.Read_data_Valid, 1);
      if (bus.Read_data_Valid && bus.Read_data_Ready) delivered++;
      tick();
    end
    bus.Read_data_Ready = 1;
    #1 check("t6_rready", bus.cpu_mem_rready, 1);
    check("t6_rdata", bus.Read_data, 32'h12345678);
    if (bus.Read_data_Valid && bus.Read_data_Ready) delivered++;
    tick();
    bus.cpu_mem_rvalid = 0; bus.cpu_mem_rlast = 0;
    #1 check("t6_rdv_off", bus.Read_data_Valid, 0);
    check("t6_rready_off", bus.cpu_mem_rready, 0);
    check("t6_once", 64'(delivered), 1);
    bus.MemWrite = 1; bus.Address = 32'h84;
    #1 check("t6_idle", bus.Mem_Req_Ready, 1);
    tick();
    bus.MemWrite = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
